// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared constants for the hazard/forwarding controller.
//   FWD_*       : ForwardAE/ForwardBE mux select encodings
//   mc_state_e  : multi-cycle execute FSM states
package hazard_ctrl_mc_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_W    = 2'b01;  // operand from ResultW
  localparam logic [1:0] FWD_M    = 2'b10;  // operand from ALUResultM

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forward mux select for the E stage.
//   rs           in  source register of the operand in E
//   rd_m/rd_w    in  destination registers in M and W
//   reg_write_*  in  M/W write-enable
//   sel          out FWD_M / FWD_W / FWD_NONE (M wins over W, x0 never forwarded)
// With FWD_EN=0 the select is tied to FWD_NONE.
module hazard_fwd_sel
  import hazard_ctrl_mc_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_w,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_NONE;
    if (FWD_EN != 0) begin
      if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
        sel = FWD_M;
      end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
        sel = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller for the 5-stage pipeline with a variable-latency
// multi-cycle execute unit.
//   Inputs : D/E/M/W register addresses and write enables, ResultSrcE0 (load in E),
//            McStartE (multi-cycle op in E), PCSrcE (taken branch in E)
//   Outputs: StallF/D/E, FlushD/E/M, ForwardAE/BE (combinational, forced idle in reset),
//            McBusy (registered FSM state), three saturating perf counters.
// Handshake-free block: every output is a per-cycle level; no valid/ready.
module hazard_ctrl_mc
  import hazard_ctrl_mc_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MC_LATENCY = 4,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              RegWriteE,
  input  logic              ResultSrcE0,
  input  logic              McStartE,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              McBusy,
  output logic [CNT_W-1:0]  LoadUseCnt,
  output logic [CNT_W-1:0]  McStallCnt,
  output logic [CNT_W-1:0]  BranchFlushCnt
);

  localparam int CW = $clog2(MC_LATENCY) + 1;
  localparam bit MULTI = (MC_LATENCY > 1);
  localparam bit FWD = (FWD_EN != 0);
  // First cycle in E is spent in IDLE, the last in BUSY with mc_cnt==0.
  localparam int LOAD_I = MULTI ? (MC_LATENCY - 2) : 0;
  localparam logic [CW-1:0] MC_LOAD = LOAD_I[CW-1:0];

  mc_state_e       state, state_n;
  logic [CW-1:0]   mc_cnt, mc_cnt_n;
  logic            mc_hold;
  logic            lw_stall, raw, d_hz;
  logic [1:0]      fwd_a, fwd_b;

  hazard_fwd_sel #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_a (
    .rs(Rs1E), .rd_m(RdM), .reg_write_m(RegWriteM),
    .rd_w(RdW), .reg_write_w(RegWriteW), .sel(fwd_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_b (
    .rs(Rs2E), .rd_m(RdM), .reg_write_m(RegWriteM),
    .rd_w(RdW), .reg_write_w(RegWriteW), .sel(fwd_b)
  );

  // Load-use: only meaningful when forwarding is on.
  assign lw_stall = FWD && ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Without forwarding any pending E/M write to a D source stalls; W is covered
  // by the write-through register file.
  assign raw = !FWD && (
      ((Rs1D != '0) && ((RegWriteE && (RdE == Rs1D)) || (RegWriteM && (RdM == Rs1D)))) ||
      ((Rs2D != '0) && ((RegWriteE && (RdE == Rs2D)) || (RegWriteM && (RdM == Rs2D)))));

  assign d_hz = lw_stall || raw;

  assign mc_hold = ((state == MC_IDLE) && McStartE && MULTI) ||
                   ((state == MC_BUSY) && (mc_cnt != '0));

  assign McBusy = (state == MC_BUSY);

  // FSM next state
  always_comb begin
    state_n  = state;
    mc_cnt_n = mc_cnt;
    case (state)
      MC_IDLE: begin
        if (McStartE && MULTI) begin
          state_n  = MC_BUSY;
          mc_cnt_n = MC_LOAD;
        end
      end
      MC_BUSY: begin
        if (mc_cnt != '0) mc_cnt_n = mc_cnt - CW'(1);
        else              state_n  = MC_IDLE;
      end
      default: state_n = MC_IDLE;
    endcase
  end

  // Stall/flush priority: reset > multi-cycle hold > branch/data hazard.
  // A taken branch drops the D/F stall so the PC can take the redirect;
  // the hazarding instruction in D is flushed anyway.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    ForwardAE = FWD_NONE;
    ForwardBE = FWD_NONE;
    if (!rst) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      if (mc_hold) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else begin
        FlushD = PCSrcE;
        FlushE = PCSrcE || d_hz;
        StallF = d_hz && !PCSrcE;
        StallD = d_hz && !PCSrcE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= MC_IDLE;
      mc_cnt         <= '0;
      LoadUseCnt     <= '0;
      McStallCnt     <= '0;
      BranchFlushCnt <= '0;
    end else begin
      state  <= state_n;
      mc_cnt <= mc_cnt_n;
      // Events are counted even when mc_hold masks their effect.
      if (d_hz && (LoadUseCnt != '1))      LoadUseCnt     <= LoadUseCnt + CNT_W'(1);
      if (mc_hold && (McStallCnt != '1))   McStallCnt     <= McStallCnt + CNT_W'(1);
      if (PCSrcE && (BranchFlushCnt != '1)) BranchFlushCnt <= BranchFlushCnt + CNT_W'(1);
    end
  end

endmodule
